// File: rtl/cpu_dma_rx_pkt_reader.sv
// Drains complete packets from the CPU DMA queue FWFT read port and forwards them to the
// host DMA engine as a valid/ready word stream, reporting length, error and statistics.
module cpu_dma_rx_pkt_reader #(
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int unsigned MAX_PKT_WORDS  = 512,
  parameter int unsigned LEN_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      cpu_q_dma_pkt_avail,
  output logic                      cpu_q_dma_rd,
  input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
  input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
  output logic [DMA_DATA_WIDTH-1:0] dma_rx_data,
  output logic [DMA_CTRL_WIDTH-1:0] dma_rx_be,
  output logic                      dma_rx_eop,
  output logic                      dma_rx_vld,
  input  logic                      dma_rx_rdy,
  output logic                      dma_rx_done,
  output logic [LEN_WIDTH-1:0]      dma_rx_len,
  output logic                      dma_rx_err,
  output logic [31:0]               pkt_count,
  output logic [15:0]               err_count
);

  localparam int unsigned WCNT_W = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [2:0] {StIdle, StRead, StDone, StGap1, StGap2} state_e;

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_q, err_d;
  logic [31:0]           pkt_count_q, pkt_count_d;
  logic [15:0]           err_count_q, err_count_d;

  logic                      last_word;
  logic                      malformed;
  logic [2:0]                last_bytes;
  logic [DMA_CTRL_WIDTH-1:0] last_be;
  logic                      forwarding;
  logic                      dropping;
  logic                      xfer;

  assign last_word = |cpu_q_dma_rd_ctrl;

  always_comb begin
    last_bytes = 3'd4;
    last_be    = {DMA_CTRL_WIDTH{1'b1}};
    malformed  = 1'b0;
    case (cpu_q_dma_rd_ctrl)
      4'b0000: ;
      4'b1000: begin last_bytes = 3'd1; last_be = 4'b0001; end
      4'b0100: begin last_bytes = 3'd2; last_be = 4'b0011; end
      4'b0010: begin last_bytes = 3'd3; last_be = 4'b0111; end
      4'b0001: begin last_bytes = 3'd4; last_be = 4'b1111; end
      default: malformed = 1'b1;
    endcase
  end

  // Once MAX_PKT_WORDS words have gone out without an eop, the rest of the packet is flushed.
  assign forwarding = (state_q == StRead) && (word_cnt_q < WCNT_W'(MAX_PKT_WORDS));
  assign dropping   = (state_q == StRead) && !forwarding;
  assign xfer       = forwarding && dma_rx_rdy;

  assign dma_rx_vld   = forwarding;
  assign dma_rx_data  = forwarding ? cpu_q_dma_rd_data : '0;
  assign dma_rx_be    = forwarding ? last_be : '0;
  assign dma_rx_eop   = forwarding && last_word;
  assign cpu_q_dma_rd = forwarding ? dma_rx_rdy : dropping;
  assign dma_rx_done  = (state_q == StDone);
  assign dma_rx_len   = len_q;
  assign dma_rx_err   = err_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    err_d       = err_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    unique case (state_q)
      StIdle: begin
        word_cnt_d = '0;
        if (enable && cpu_q_dma_pkt_avail) state_d = StRead;
      end
      StRead: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            // word_cnt_q counts the full words ahead of this last one.
            len_d   = LEN_WIDTH'({word_cnt_q, 2'b00}) + LEN_WIDTH'(last_bytes);
            err_d   = malformed;
            state_d = StDone;
          end
        end else if (dropping && last_word) begin
          len_d   = LEN_WIDTH'(4 * MAX_PKT_WORDS);
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        pkt_count_d = pkt_count_q + 32'd1;
        if (err_q && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
        state_d = StGap1;
      end
      StGap1: state_d = StGap2;
      StGap2: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      err_q       <= err_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_cpu_dma_rx_pkt_reader.sv
// Bench for cpu_dma_rx_pkt_reader: FWFT queue model feeding directed packets, with a
// table of single packets plus hand sequences for stalls, oversize, spacing and reset.
module tb_cpu_dma_rx_pkt_reader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        cpu_q_dma_pkt_avail;
  logic        cpu_q_dma_rd;
  logic [31:0] cpu_q_dma_rd_data;
  logic [3:0]  cpu_q_dma_rd_ctrl;
  logic [31:0] dma_rx_data;
  logic [3:0]  dma_rx_be;
  logic        dma_rx_eop;
  logic        dma_rx_vld;
  logic        dma_rx_rdy = 1'b0;
  logic        dma_rx_done;
  logic [11:0] dma_rx_len;
  logic        dma_rx_err;
  logic [31:0] pkt_count;
  logic [15:0] err_count;

  cpu_dma_rx_pkt_reader #(
    .DMA_DATA_WIDTH(32),
    .DMA_CTRL_WIDTH(4),
    .MAX_PKT_WORDS (MAXW),
    .LEN_WIDTH     (12)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .cpu_q_dma_pkt_avail(cpu_q_dma_pkt_avail),
    .cpu_q_dma_rd       (cpu_q_dma_rd),
    .cpu_q_dma_rd_data  (cpu_q_dma_rd_data),
    .cpu_q_dma_rd_ctrl  (cpu_q_dma_rd_ctrl),
    .dma_rx_data        (dma_rx_data),
    .dma_rx_be          (dma_rx_be),
    .dma_rx_eop         (dma_rx_eop),
    .dma_rx_vld         (dma_rx_vld),
    .dma_rx_rdy         (dma_rx_rdy),
    .dma_rx_done        (dma_rx_done),
    .dma_rx_len         (dma_rx_len),
    .dma_rx_err         (dma_rx_err),
    .pkt_count          (pkt_count),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  // FWFT queue model; pkt_avail lags the packet count by two registers.
  logic [35:0] mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr;
  int          eop_in = 0;
  int          eop_out;
  logic        avail_d1;
  logic        fifo_empty;

  assign fifo_empty        = (rd_ptr == wr_ptr);
  assign cpu_q_dma_rd_data = fifo_empty ? 32'h0 : mem[rd_ptr][31:0];
  assign cpu_q_dma_rd_ctrl = fifo_empty ? 4'h0 : mem[rd_ptr][35:32];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr              <= wr_ptr;
      eop_out             <= eop_in;
      avail_d1            <= 1'b0;
      cpu_q_dma_pkt_avail <= 1'b0;
    end else begin
      if (cpu_q_dma_rd && !fifo_empty) begin
        rd_ptr <= rd_ptr + 8'd1;
        if (mem[rd_ptr][35:32] != 4'h0) eop_out <= eop_out + 1;
      end
      avail_d1            <= (eop_in != eop_out);
      cpu_q_dma_pkt_avail <= avail_d1;
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  int exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input int id, input int idx);
    logic [7:0]  id8;
    logic [15:0] ix;
    id8 = id[7:0];
    ix  = idx[15:0];
    return {id8, 8'h5A, ix};
  endfunction

  task automatic push_pkt(input int id, input int n, input logic [3:0] lctrl);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = {(i == n - 1) ? lctrl : 4'h0, wdata(id, i)};
      wr_ptr = wr_ptr + 8'd1;
    end
    eop_in++;
  endtask

  // Consumes one packet; pre returns the idle samples seen before its first valid word.
  task automatic run_pkt(input int id, input int n, input logic [3:0] be_last,
                         input int exp_len, input logic exp_err, input logic [15:0] rdy_pat,
                         output int pre);
    int fwd_exp, xfers, drops, vk;
    bit seen_done, started;
    fwd_exp = (n < MAXW) ? n : MAXW;
    xfers = 0; drops = 0; vk = 0; seen_done = 0; started = 0; pre = 0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      @(negedge clk);
      #1;
      if (dma_rx_vld) begin
        dma_rx_rdy = (vk < 16) ? rdy_pat[vk[3:0]] : 1'b1;
        vk++;
      end else begin
        dma_rx_rdy = 1'b0;
      end
      #1;
      if (dma_rx_vld) begin
        started = 1;
        chk("data", dma_rx_data, wdata(id, xfers));
        chk("be", {28'h0, dma_rx_be}, {28'h0, (xfers == n - 1) ? be_last : 4'hF});
        chk("eop", {31'h0, dma_rx_eop}, {31'h0, (xfers == n - 1)});
        chk("rd_follows_rdy", {31'h0, cpu_q_dma_rd}, {31'h0, dma_rx_rdy});
        if (dma_rx_rdy) xfers++;
      end else begin
        if (!started && !dma_rx_done) pre++;
        if (cpu_q_dma_rd) begin
          if (xfers == fwd_exp && fwd_exp < n) drops++;
          else chk("spurious_rd", 32'd1, 32'd0);
        end
      end
      if (dma_rx_done) begin
        seen_done = 1;
        chk("len", {20'h0, dma_rx_len}, exp_len);
        chk("err", {31'h0, dma_rx_err}, {31'h0, exp_err});
        chk("fwd_words", xfers, fwd_exp);
        chk("dropped_words", drops, n - fwd_exp);
      end
    end
    dma_rx_rdy = 1'b0;
    chk("done_seen", {31'h0, seen_done}, 32'd1);
    exp_pkts++;
    if (exp_err) exp_errs++;
    @(negedge clk);
    #1;
    chk("done_one_cycle", {31'h0, dma_rx_done}, 32'd0);
    chk("pkt_count", pkt_count, exp_pkts);
    chk("err_count", {16'h0, err_count}, exp_errs);
  endtask

  typedef struct {
    int         n;
    logic [3:0] lctrl;
    logic [3:0] be_last;
    int         len;
    logic       err;
  } vec_t;

  vec_t vecs [9];
  int   pre;
  int   cnt;

  initial begin
    vecs[0] = '{1, 4'b1000, 4'b0001, 1, 1'b0};
    vecs[1] = '{1, 4'b0100, 4'b0011, 2, 1'b0};
    vecs[2] = '{1, 4'b0010, 4'b0111, 3, 1'b0};
    vecs[3] = '{1, 4'b0001, 4'b1111, 4, 1'b0};
    vecs[4] = '{1, 4'b0110, 4'b1111, 4, 1'b1};
    vecs[5] = '{2, 4'b1000, 4'b0001, 5, 1'b0};
    vecs[6] = '{4, 4'b0010, 4'b0111, 15, 1'b0};  // exactly MAXW words: not oversize
    vecs[7] = '{3, 4'b1111, 4'b1111, 12, 1'b1};
    vecs[8] = '{5, 4'b0001, 4'b1111, 16, 1'b1};  // one word over: dropped, len 4*MAXW

    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", {31'h0, dma_rx_vld}, 32'd0);
    chk("rst_rd", {31'h0, cpu_q_dma_rd}, 32'd0);
    chk("rst_done", {31'h0, dma_rx_done}, 32'd0);
    chk("rst_len_err", {19'h0, dma_rx_err, dma_rx_len}, 32'd0);
    chk("rst_counts", pkt_count | {16'h0, err_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 3-word packet, continuous ready
    push_pkt(1, 3, 4'b0100);
    run_pkt(1, 3, 4'b0011, 10, 1'b0, 16'hFFFF, pre);

    // Same packet with ready 1,0,0,1,1
    push_pkt(2, 3, 4'b0100);
    run_pkt(2, 3, 4'b0011, 10, 1'b0, 16'hFFF9, pre);

    // Oversize: 6 words, 4 forwarded, 2 dropped
    push_pkt(3, 6, 4'b0001);
    run_pkt(3, 6, 4'b1111, 16, 1'b1, 16'hFFFF, pre);

    // Back-to-back: done at sample t, GAP t+1..t+2, IDLE t+3, first word t+4.
    // run_pkt spends sample t+1 on counters, so two idle samples precede the second packet.
    push_pkt(4, 2, 4'b1000);
    push_pkt(5, 3, 4'b0010);
    run_pkt(4, 2, 4'b0001, 5, 1'b0, 16'hFFFF, pre);
    run_pkt(5, 3, 4'b0111, 11, 1'b0, 16'hFFFF, pre);
    chk("b2b_spacing", pre, 2);

    // enable low holds off a waiting packet
    enable = 1'b0;
    push_pkt(6, 2, 4'b0001);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (dma_rx_vld || cpu_q_dma_rd) cnt++;
    end
    chk("enable_low_idle", cnt, 0);
    enable = 1'b1;
    run_pkt(6, 2, 4'b1111, 8, 1'b0, 16'hFFFF, pre);

    for (int i = 0; i < 9; i++) begin
      push_pkt(10 + i, vecs[i].n, vecs[i].lctrl);
      run_pkt(10 + i, vecs[i].n, vecs[i].be_last, vecs[i].len, vecs[i].err, 16'hFFFF, pre);
    end

    // Reset after 2 of 5 words
    push_pkt(30, 5, 4'b0001);
    cnt = 0;
    for (int cyc = 0; cyc < 100 && cnt < 2; cyc++) begin
      @(negedge clk);
      #1;
      dma_rx_rdy = 1'b1;
      #1;
      if (dma_rx_vld) cnt++;
    end
    chk("pre_reset_words", cnt, 2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'h0, dma_rx_vld}, 32'd0);
    chk("mid_rst_rd", {31'h0, cpu_q_dma_rd}, 32'd0);
    chk("mid_rst_data", dma_rx_data, 32'd0);
    chk("mid_rst_be_eop", {27'h0, dma_rx_eop, dma_rx_be}, 32'd0);
    chk("mid_rst_len_err", {19'h0, dma_rx_err, dma_rx_len}, 32'd0);
    chk("mid_rst_pkt_count", pkt_count, 32'd0);
    chk("mid_rst_err_count", {16'h0, err_count}, 32'd0);
    dma_rx_rdy = 1'b0;
    exp_pkts = 0;
    exp_errs = 0;
    @(negedge clk);
    reset_n = 1'b1;
    push_pkt(31, 2, 4'b0010);
    run_pkt(31, 2, 4'b0111, 7, 1'b0, 16'hFFFF, pre);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
